// File: rtl/button_input.sv
// Debounced push-button conditioner: 2-flop synchroniser, debounce FSM, and
// registered level / press / release / long-press / press-count outputs.
module button_input #(
  parameter int DEBOUNCE_CYCLES = 480000,
  parameter int LONG_CYCLES     = 48000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn,
  output logic       o_level,
  output logic       o_press,
  output logic       o_release,
  output logic       o_long,
  output logic [7:0] o_press_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  // The entry cycle leaves the counter at 0, so acceptance happens at N-2.
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 2);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYCLES - 1);
  localparam logic          POL      = (ACTIVE_LOW != 0);

  generate
    if (LONG_CYCLES <= DEBOUNCE_CYCLES || DEBOUNCE_CYCLES < 2) begin : g_param_check
      $error("button_input: need DEBOUNCE_CYCLES >= 2 and LONG_CYCLES > DEBOUNCE_CYCLES");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_UP      = 2'd0,
    S_DN_WAIT = 2'd1,
    S_DN      = 2'd2,
    S_UP_WAIT = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [1:0]      sync;
  logic            s;
  logic [DW-1:0]   db_cnt, db_cnt_next;
  logic [HW-1:0]   hold_cnt, hold_cnt_next;
  logic            level_next, press_next, release_next, long_next;
  logic [7:0]      count_next;

  assign s = sync[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], i_btn ^ POL};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_UP;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      o_level       <= 1'b0;
      o_press       <= 1'b0;
      o_release     <= 1'b0;
      o_long        <= 1'b0;
      o_press_count <= 8'd0;
    end else begin
      state         <= state_next;
      db_cnt        <= db_cnt_next;
      hold_cnt      <= hold_cnt_next;
      o_level       <= level_next;
      o_press       <= press_next;
      o_release     <= release_next;
      o_long        <= long_next;
      o_press_count <= count_next;
    end
  end

  always_comb begin
    state_next    = state;
    db_cnt_next   = db_cnt;
    hold_cnt_next = hold_cnt;
    level_next    = o_level;
    press_next    = 1'b0;
    release_next  = 1'b0;
    long_next     = 1'b0;
    count_next    = o_press_count;

    // Hold time keeps accumulating through release bounces; saturates at the long mark.
    if (state == S_DN || state == S_UP_WAIT) begin
      if (hold_cnt != HOLD_MAX) begin
        hold_cnt_next = hold_cnt + HW'(1);
        long_next     = (hold_cnt == HOLD_PRE);
      end else begin
        hold_cnt_next = hold_cnt;
      end
    end else begin
      hold_cnt_next = hold_cnt;
    end

    case (state)
      S_UP: begin
        level_next  = 1'b0;
        db_cnt_next = '0;
        if (s) begin
          state_next = S_DN_WAIT;
        end else begin
          state_next = S_UP;
        end
      end
      S_DN_WAIT: begin
        level_next = 1'b0;
        if (!s) begin
          state_next  = S_UP;
          db_cnt_next = '0;
        end else if (db_cnt == DB_LAST) begin
          state_next    = S_DN;
          db_cnt_next   = '0;
          level_next    = 1'b1;
          press_next    = 1'b1;
          count_next    = o_press_count + 8'd1;
          hold_cnt_next = '0;
        end else begin
          db_cnt_next = db_cnt + DW'(1);
        end
      end
      S_DN: begin
        level_next  = 1'b1;
        db_cnt_next = '0;
        if (!s) begin
          state_next = S_UP_WAIT;
        end else begin
          state_next = S_DN;
        end
      end
      S_UP_WAIT: begin
        level_next = 1'b1;
        if (s) begin
          state_next  = S_DN;
          db_cnt_next = '0;
        end else if (db_cnt == DB_LAST) begin
          state_next   = S_UP;
          db_cnt_next  = '0;
          level_next   = 1'b0;
          release_next = 1'b1;
        end else begin
          db_cnt_next = db_cnt + DW'(1);
        end
      end
      default: begin
        state_next    = S_UP;
        db_cnt_next   = '0;
        hold_cnt_next = '0;
        level_next    = 1'b0;
        long_next     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_input.sv
// Directed bench for button_input with an event scoreboard: expected pulses
// (kind, cycle) are queued when the pin is driven and matched as they appear.
module tb_button_input;

  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_LONG    = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn;
  logic       o_level, o_press, o_release, o_long;
  logic [7:0] o_press_count;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc     = 0;
  int  checks  = 0;
  int  errors  = 0;
  int  exp_cnt = 0;

  button_input #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .ACTIVE_LOW     (1)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_btn        (btn),
    .o_level      (o_level),
    .o_press      (o_press),
    .o_release    (o_release),
    .o_long       (o_long),
    .o_press_count(o_press_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic see(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", kind, -1);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (o_press)   see(EV_PRESS);
    if (o_release) see(EV_RELEASE);
    if (o_long)    see(EV_LONG);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int outs();
    return int'({o_level, o_press, o_release, o_long, o_press_count});
  endfunction

  initial begin
    rst_n = 1'b1;
    btn   = 1'b1;
    #2;
    // Reset held with the button pressed: outputs stay zero.
    rst_n = 1'b0;
    btn   = 1'b0;
    chk("reset_async_outputs", outs(), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_outputs", outs(), 0);
    end
    rst_n = 1'b1;
    push_ev(EV_PRESS, cyc + 6);
    exp_cnt = 1;
    ticks(10);
    chk("reset_press_done", exp_q.size(), 0);
    chk("reset_level", int'(o_level), 1);
    chk("reset_count", int'(o_press_count), exp_cnt);

    btn = 1'b1;
    push_ev(EV_RELEASE, cyc + 6);
    ticks(10);
    chk("reset_release_done", exp_q.size(), 0);
    chk("level_after_release", int'(o_level), 0);

    // Clean press held 10 cycles, then release.
    btn = 1'b0;
    push_ev(EV_PRESS, cyc + 6);
    exp_cnt++;
    ticks(10);
    chk("clean_level_high", int'(o_level), 1);
    btn = 1'b1;
    push_ev(EV_RELEASE, cyc + 6);
    ticks(10);
    chk("clean_done", exp_q.size(), 0);
    chk("clean_level_low", int'(o_level), 0);
    chk("clean_count", int'(o_press_count), exp_cnt);

    // Bounce: toggle every 2 cycles for 20 cycles, then settle pressed.
    for (int i = 0; i < 10; i++) begin
      btn = (i % 2 == 0) ? 1'b0 : 1'b1;
      ticks(2);
    end
    chk("bounce_no_level", int'(o_level), 0);
    btn = 1'b0;
    push_ev(EV_PRESS, cyc + 6);
    exp_cnt++;
    ticks(10);
    chk("bounce_done", exp_q.size(), 0);
    chk("bounce_count", int'(o_press_count), exp_cnt);
    btn = 1'b1;
    push_ev(EV_RELEASE, cyc + 6);
    ticks(10);
    chk("bounce_release_done", exp_q.size(), 0);

    // Long press, then a 3-cycle release glitch that must be swallowed.
    btn = 1'b0;
    push_ev(EV_PRESS, cyc + 6);
    push_ev(EV_LONG, cyc + 26);
    exp_cnt++;
    ticks(30);
    chk("long_seen", exp_q.size(), 0);
    btn = 1'b1;
    ticks(3);
    btn = 1'b0;
    ticks(10);
    chk("glitch_level", int'(o_level), 1);
    btn = 1'b1;
    push_ev(EV_RELEASE, cyc + 6);
    ticks(10);
    chk("long_release_done", exp_q.size(), 0);
    chk("long_count", int'(o_press_count), exp_cnt);

    // Count wrap over 257 presses.
    for (int i = 0; i < 257; i++) begin
      btn = 1'b0;
      push_ev(EV_PRESS, cyc + 6);
      exp_cnt = (exp_cnt + 1) % 256;
      ticks(8);
      btn = 1'b1;
      push_ev(EV_RELEASE, cyc + 6);
      ticks(8);
      chk("wrap_count", int'(o_press_count), exp_cnt);
    end
    chk("wrap_done", exp_q.size(), 0);

    // Asynchronous reset in the middle of a hold abandons the press.
    btn = 1'b0;
    push_ev(EV_PRESS, cyc + 6);
    exp_cnt++;
    ticks(10);
    chk("midhold_level", int'(o_level), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midhold_async_clear", outs(), 0);
    btn = 1'b1;
    exp_cnt = 0;
    ticks(3);
    rst_n = 1'b1;
    ticks(30);
    chk("midhold_no_events", exp_q.size(), 0);
    chk("midhold_outputs", outs(), 0);
    chk("midhold_count", int'(o_press_count), exp_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
